// File: rtl/rvfpm_pkg.sv
// Shared rvfpm definitions: default widths and the queued-instruction record
// used by the issue queue, the pipeline and the bench.
package rvfpm_pkg;

   localparam int FPQ_X_ID_WIDTH = 4;
   localparam int FPQ_DEPTH      = 4;
   localparam int FPQ_XLEN       = 32;

   typedef struct packed {
      logic [31:0]               instr;
      logic [FPQ_X_ID_WIDTH-1:0] id;
      logic [FPQ_XLEN-1:0]       rs1;
   } fpq_entry_t;

endpackage

// File: rtl/fpu_instr_queue.sv
// In-order issue queue for offloaded FP instructions feeding the rvfpm pipeline.
// Circular buffer with explicit occupancy; head entry is shown combinationally.
module fpu_instr_queue
   import rvfpm_pkg::*;
#(
   parameter int X_ID_WIDTH  = FPQ_X_ID_WIDTH,
   parameter int QUEUE_DEPTH = FPQ_DEPTH,
   parameter int XLEN        = FPQ_XLEN
) (
   input  logic                                ck,
   input  logic                                rst,
   input  logic                                enable,
   input  logic                                flush,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [31:0]                         in_instr,
   input  logic [X_ID_WIDTH-1:0]               in_id,
   input  logic [XLEN-1:0]                     in_rs1,
   output logic                                out_valid,
   input  logic                                fpu_ready,
   output logic [31:0]                         out_instr,
   output logic [X_ID_WIDTH-1:0]               out_id,
   output logic [XLEN-1:0]                     out_rs1,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]    count,
   output logic [QUEUE_DEPTH*X_ID_WIDTH-1:0]   queue_ids,
   output logic [QUEUE_DEPTH-1:0]              queue_valid
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = $clog2(QUEUE_DEPTH+1);

   logic [31:0]           instr_mem_r [QUEUE_DEPTH];
   logic [X_ID_WIDTH-1:0] id_mem_r    [QUEUE_DEPTH];
   logic [XLEN-1:0]       rs1_mem_r   [QUEUE_DEPTH];
   logic [PTR_W-1:0]      head_r;
   logic [PTR_W-1:0]      tail_r;
   logic [CNT_W-1:0]      count_r;

   logic in_ready_s;
   logic out_valid_s;
   logic push_s;
   logic pop_s;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_W'(QUEUE_DEPTH-1)) begin
         nxt = '0;
      end else begin
         nxt = ptr + PTR_W'(1);
      end
      return nxt;
   endfunction

   // Handshake qualifiers; in_ready deliberately ignores a same-cycle pop.
   always_comb begin
      in_ready_s  = !rst && enable && !flush && (count_r != CNT_W'(QUEUE_DEPTH));
      out_valid_s = !rst && enable && (count_r != CNT_W'(0));
      push_s      = in_valid && in_ready_s;
      pop_s       = out_valid_s && fpu_ready && !flush;
   end

   // Pointer, occupancy and storage update.
   always_ff @(posedge ck) begin
      if (rst) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            instr_mem_r[i] <= '0;
            id_mem_r[i]    <= '0;
            rs1_mem_r[i]   <= '0;
         end
      end else if (enable && flush) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else if (enable) begin
         if (push_s) begin
            instr_mem_r[tail_r] <= in_instr;
            id_mem_r[tail_r]    <= in_id;
            rs1_mem_r[tail_r]   <= in_rs1;
            tail_r              <= next_ptr(tail_r);
         end
         if (pop_s) begin
            head_r <= next_ptr(head_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end else begin
         count_r <= count_r;
      end
   end

   // Head entry presentation, forced to zero when nothing is valid.
   always_comb begin
      if (out_valid_s) begin
         out_instr = instr_mem_r[head_r];
         out_id    = id_mem_r[head_r];
         out_rs1   = rs1_mem_r[head_r];
      end else begin
         out_instr = '0;
         out_id    = '0;
         out_rs1   = '0;
      end
   end

   // Ordered view of occupied slots, index 0 = head.
   always_comb begin
      int slot_idx;
      slot_idx    = 0;
      queue_ids   = '0;
      queue_valid = '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         slot_idx = int'(head_r) + i;
         if (slot_idx >= QUEUE_DEPTH) begin
            slot_idx = slot_idx - QUEUE_DEPTH;
         end else begin
            slot_idx = slot_idx;
         end
         if (i < int'(count_r)) begin
            queue_ids[i*X_ID_WIDTH +: X_ID_WIDTH] = id_mem_r[slot_idx[PTR_W-1:0]];
            queue_valid[i]                        = 1'b1;
         end else begin
            queue_ids[i*X_ID_WIDTH +: X_ID_WIDTH] = '0;
            queue_valid[i]                        = 1'b0;
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign count     = count_r;

endmodule

// File: tb/tb_fpu_instr_queue.sv
// Self-checking bench for fpu_instr_queue: a depth-4 instance with a queue
// scoreboard plus a depth-3 instance exercising wrap-around ordering.
module tb_fpu_instr_queue;
   import rvfpm_pkg::*;

   logic        ck;
   logic        rst;
   logic        enable;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [3:0]  in_id;
   logic [31:0] in_rs1;
   logic        out_valid;
   logic        fpu_ready;
   logic [31:0] out_instr;
   logic [3:0]  out_id;
   logic [31:0] out_rs1;
   logic [2:0]  count;
   logic [15:0] queue_ids;
   logic [3:0]  queue_valid;

   logic        in_valid_b;
   logic        in_ready_b;
   logic [3:0]  in_id_b;
   logic        out_valid_b;
   logic        fpu_ready_b;
   logic [31:0] out_instr_b;
   logic [3:0]  out_id_b;
   logic [31:0] out_rs1_b;
   logic [1:0]  count_b;
   logic [11:0] queue_ids_b;
   logic [2:0]  queue_valid_b;
   logic        flush_b;
   logic [31:0] zero32;

   int checks;
   int errors;

   fpq_entry_t  exp_q[$];
   logic [3:0]  exp_b_q[$];

   fpu_instr_queue #(.X_ID_WIDTH(4), .QUEUE_DEPTH(4), .XLEN(32)) dut (
      .ck(ck), .rst(rst), .enable(enable), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_id(in_id), .in_rs1(in_rs1), .out_valid(out_valid),
      .fpu_ready(fpu_ready), .out_instr(out_instr), .out_id(out_id),
      .out_rs1(out_rs1), .count(count), .queue_ids(queue_ids),
      .queue_valid(queue_valid)
   );

   fpu_instr_queue #(.X_ID_WIDTH(4), .QUEUE_DEPTH(3), .XLEN(32)) dut_b (
      .ck(ck), .rst(rst), .enable(1'b1), .flush(flush_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_instr(zero32),
      .in_id(in_id_b), .in_rs1(zero32), .out_valid(out_valid_b),
      .fpu_ready(fpu_ready_b), .out_instr(out_instr_b), .out_id(out_id_b),
      .out_rs1(out_rs1_b), .count(count_b), .queue_ids(queue_ids_b),
      .queue_valid(queue_valid_b)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [3:0] id, input logic [31:0] instr,
                          input logic [31:0] rs1);
      in_valid = v;
      in_id    = id;
      in_instr = instr;
      in_rs1   = rs1;
   endtask

   // Scoreboard monitor for the depth-4 queue, sampled mid-cycle.
   always @(negedge ck) begin
      bit          exp_val;
      bit          exp_rdy;
      logic [15:0] ids;
      logic [3:0]  vmask;
      fpq_entry_t  e;
      exp_val = !rst && enable && (exp_q.size() != 0);
      exp_rdy = !rst && enable && !flush && (exp_q.size() != 4);
      chk("count", 128'(count), 128'(exp_q.size()));
      chk("in_ready", 128'(in_ready), 128'(exp_rdy));
      chk("out_valid", 128'(out_valid), 128'(exp_val));
      if (exp_val) begin
         chk("out_instr", 128'(out_instr), 128'(exp_q[0].instr));
         chk("out_id", 128'(out_id), 128'(exp_q[0].id));
         chk("out_rs1", 128'(out_rs1), 128'(exp_q[0].rs1));
      end else begin
         chk("out_zero", 128'({out_instr, out_id, out_rs1}), 128'(0));
      end
      ids   = '0;
      vmask = '0;
      for (int i = 0; i < exp_q.size(); i++) begin
         ids[i*4 +: 4] = exp_q[i].id;
         vmask[i]      = 1'b1;
      end
      chk("queue_ids", 128'(queue_ids), 128'(ids));
      chk("queue_valid", 128'(queue_valid), 128'(vmask));
      if (rst) begin
         exp_q.delete();
      end else if (enable) begin
         if (flush) begin
            exp_q.delete();
         end else begin
            if (exp_val && fpu_ready) void'(exp_q.pop_front());
            if (in_valid && exp_rdy) begin
               e.instr = in_instr;
               e.id    = in_id;
               e.rs1   = in_rs1;
               exp_q.push_back(e);
            end
         end
      end
   end

   // Ordering monitor for the depth-3 queue.
   always @(negedge ck) begin
      bit         exp_val;
      bit         exp_rdy;
      logic [3:0] want;
      exp_val = !rst && (exp_b_q.size() != 0);
      exp_rdy = !rst && (exp_b_q.size() != 3);
      chk("b_count", 128'(count_b), 128'(exp_b_q.size()));
      chk("b_out_valid", 128'(out_valid_b), 128'(exp_val));
      chk("b_in_ready", 128'(in_ready_b), 128'(exp_rdy));
      if (rst) begin
         exp_b_q.delete();
      end else begin
         if (exp_val && fpu_ready_b) begin
            want = exp_b_q.pop_front();
            chk("b_out_id", 128'(out_id_b), 128'(want));
         end
         if (in_valid_b && exp_rdy) exp_b_q.push_back(in_id_b);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      zero32 = 32'h0;
      rst = 1'b1; enable = 1'b1; flush = 1'b0; fpu_ready = 1'b0;
      drive_a(1'b0, 4'h0, 32'h0, 32'h0);
      in_valid_b = 1'b0; in_id_b = 4'h0; fpu_ready_b = 1'b0; flush_b = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      #1;
      chk("rst_count", 128'(count), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_qvalid", 128'(queue_valid), 128'(0));

      // Fill to full with ids 1..4.
      for (int k = 1; k <= 4; k++) begin
         drive_a(1'b1, 4'(k), 32'h1000 + 32'(k), 32'(k * 3));
         step();
      end
      drive_a(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk("full_count", 128'(count), 128'(4));
      chk("full_in_ready", 128'(in_ready), 128'(0));
      chk("full_ids", 128'(queue_ids), 128'(16'h4321));
      chk("full_qvalid", 128'(queue_valid), 128'(4'hf));

      // Pop from full while offering id 5: not accepted that cycle.
      drive_a(1'b1, 4'h5, 32'h1005, 32'h0000_0015);
      fpu_ready = 1'b1;
      step();
      fpu_ready = 1'b0;
      #1;
      chk("pop_full_count", 128'(count), 128'(3));
      chk("pop_full_ids", 128'(queue_ids), 128'(16'h0432));
      chk("pop_full_rdy", 128'(in_ready), 128'(1));
      step();
      drive_a(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk("refill_ids", 128'(queue_ids), 128'(16'h5432));

      fpu_ready = 1'b1;
      repeat (4) step();
      fpu_ready = 1'b0;
      #1;
      chk("drain_count", 128'(count), 128'(0));

      // Latency: visible exactly one cycle after the push edge.
      drive_a(1'b1, 4'h7, 32'h00A5_7553, 32'hDEAD_BEEF);
      #1;
      chk("lat_pre_valid", 128'(out_valid), 128'(0));
      step();
      drive_a(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk("lat_valid", 128'(out_valid), 128'(1));
      chk("lat_instr", 128'(out_instr), 128'(32'h00A5_7553));
      chk("lat_id", 128'(out_id), 128'(4'h7));
      fpu_ready = 1'b1;
      step();
      fpu_ready = 1'b0;

      // Steady push+pop at occupancy 2 on both depths, across pointer wrap.
      for (int k = 0; k < 2; k++) begin
         drive_a(1'b1, 4'(8 + k), 32'h2000 + 32'(k), 32'(k));
         in_valid_b = 1'b1; in_id_b = 4'(8 + k);
         step();
      end
      for (int k = 0; k < 10; k++) begin
         drive_a(1'b1, 4'(10 + k), 32'h3000 + 32'(k), 32'(100 + k));
         in_valid_b = 1'b1; in_id_b = 4'(10 + k);
         fpu_ready = 1'b1; fpu_ready_b = 1'b1;
         step();
         chk("steady_count", 128'(count), 128'(2));
         chk("steady_count_b", 128'(count_b), 128'(2));
      end
      drive_a(1'b0, 4'h0, 32'h0, 32'h0);
      in_valid_b = 1'b0; fpu_ready = 1'b0; fpu_ready_b = 1'b0;
      #1;
      chk("steady_ids", 128'(queue_ids), 128'(16'h0032));
      chk("steady_ids_b", 128'(queue_ids_b), 128'(12'h032));
      fpu_ready = 1'b1; fpu_ready_b = 1'b1;
      repeat (2) step();
      fpu_ready = 1'b0; fpu_ready_b = 1'b0;

      // Flush with three queued and a fresh offer.
      for (int k = 1; k <= 3; k++) begin
         drive_a(1'b1, 4'(k), 32'h4000 + 32'(k), 32'(k));
         step();
      end
      drive_a(1'b1, 4'h9, 32'h4009, 32'h9);
      flush = 1'b1;
      #1;
      chk("flush_pre_count", 128'(count), 128'(3));
      step();
      flush = 1'b0;
      drive_a(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk("flush_count", 128'(count), 128'(0));
      chk("flush_valid", 128'(out_valid), 128'(0));
      chk("flush_qvalid", 128'(queue_valid), 128'(0));

      // Enable low freezes everything.
      for (int k = 4; k <= 5; k++) begin
         drive_a(1'b1, 4'(k), 32'h5000 + 32'(k), 32'(k));
         step();
      end
      enable = 1'b0;
      drive_a(1'b1, 4'h6, 32'h5006, 32'h6);
      fpu_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("dis_in_ready", 128'(in_ready), 128'(0));
         chk("dis_out_valid", 128'(out_valid), 128'(0));
         chk("dis_count", 128'(count), 128'(2));
         step();
      end
      enable = 1'b1;
      drive_a(1'b0, 4'h0, 32'h0, 32'h0);
      fpu_ready = 1'b0;
      #1;
      chk("dis_ids", 128'(queue_ids), 128'(16'h0054));

      // Reset mid-operation drops everything.
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("mid_rst_count", 128'(count), 128'(0));
      chk("mid_rst_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_outs", 128'({out_instr, out_id, out_rs1}), 128'(0));
      chk("mid_rst_ids", 128'(queue_ids), 128'(0));
      chk("mid_rst_qvalid", 128'(queue_valid), 128'(0));
      repeat (2) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
